mod_counter_ud: RTL and testbench

- Parametrised modulo counter, the next generation of the team's fixed 2-bit wrap-at-3 counter.
- Adds: configurable width and modulus, up/down counting, count enable, synchronous clear, parallel load with range check, a terminal-count output and a registered wrap pulse.
- Used as the generic sequencing/timebase counter in datapath and control blocks.

---
 rtl/mod_counter_ud.sv | 114 +++++++++++
 tb/tb_mod_counter_ud.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mod_counter_ud.sv
// mod_counter_ud: parametrised up/down modulo counter with enable, synchronous
// clear, range-checked parallel load, terminal-count output and registered
// wrap / load-error pulses. Counts over 0..MODULUS-1.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-low
//   en        in   count enable
//   up_dn     in   direction, 1 = up, 0 = down
//   clear     in   synchronous clear to 0 (beats load and en)
//   load      in   synchronous parallel load (beats en)
//   load_val  in   value to load; out-of-range values clamp to MODULUS-1
//   count     out  current count (registered)
//   tc        out  terminal count, combinational; high when this edge will wrap
//   wrap      out  one-cycle pulse the cycle after a wrap
//   load_err  out  one-cycle pulse the cycle after an out-of-range load
module mod_counter_ud #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("mod_counter_ud: WIDTH must be in 1..16");
        end
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_counter_ud: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    // Highest legal count, in both the extended and the register width.
    localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic             at_max;
    logic             at_zero;

    // Extended by one bit so MODULUS == 2**WIDTH compares and increments cleanly.
    assign count_ext = {1'b0, count_q};
    assign load_ext  = {1'b0, load_val};
    assign at_max    = (count_ext == MaxExt);
    assign at_zero   = (count_q == '0);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            if (load_ext <= MaxExt) begin
                count_d = load_val;
            end else begin
                count_d    = MaxVal;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = WIDTH'(count_ext + (WIDTH + 1)'(1));
                end
            end else begin
                if (at_zero) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = WIDTH'(count_ext - (WIDTH + 1)'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Gated by every higher-priority action so tc only predicts a real wrap.
    assign tc = rst & ~clear & ~load & en &
                ((up_dn & at_max) | (~up_dn & at_zero));

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_counter_ud.sv
// Bench for mod_counter_ud: three instances (4/10, 2/4, 1/2) share one
// stimulus stream and are each checked against a modulo-arithmetic model.
module tb_mod_counter_ud;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt0;
    logic [1:0] cnt1;
    logic [0:0] cnt2;
    logic [2:0] tc_v, wrap_v, lerr_v;

    int tests = 0;
    int errors = 0;

    int mods [3] = '{10, 4, 2};
    int wids [3] = '{4, 2, 1};
    int mc [3];
    int mw [3];
    int mle [3];

    always #5 clk = ~clk;

    mod_counter_ud #(.WIDTH(4), .MODULUS(10)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt0), .tc(tc_v[0]), .wrap(wrap_v[0]),
        .load_err(lerr_v[0])
    );
    mod_counter_ud #(.WIDTH(2), .MODULUS(4)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[1:0]), .count(cnt1), .tc(tc_v[1]), .wrap(wrap_v[1]),
        .load_err(lerr_v[1])
    );
    mod_counter_ud #(.WIDTH(1), .MODULUS(2)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[0:0]), .count(cnt2), .tc(tc_v[2]), .wrap(wrap_v[2]),
        .load_err(lerr_v[2])
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] got %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_count(input int i);
        case (i)
            0:       return {28'd0, cnt0};
            1:       return {30'd0, cnt1};
            default: return {31'd0, cnt2};
        endcase
    endfunction

    // One clock: check tc before the edge, advance the model, check after.
    task automatic cycle();
        int m, lv, exp_tc;
        #1;
        for (int i = 0; i < 3; i++) begin
            m = mods[i];
            exp_tc = (rst && !clear && !load && en &&
                      ((up_dn && mc[i] == m - 1) || (!up_dn && mc[i] == 0))) ? 1 : 0;
            chk("tc", i, {31'd0, tc_v[i]}, exp_tc);
        end
        for (int i = 0; i < 3; i++) begin
            m  = mods[i];
            lv = int'(load_val) % (1 << wids[i]);
            if (!rst || clear) begin
                mc[i] = 0; mw[i] = 0; mle[i] = 0;
            end else if (load) begin
                mw[i] = 0;
                if (lv <= m - 1) begin
                    mc[i] = lv; mle[i] = 0;
                end else begin
                    mc[i] = m - 1; mle[i] = 1;
                end
            end else if (en) begin
                mle[i] = 0;
                if (up_dn) begin
                    mw[i] = (mc[i] == m - 1) ? 1 : 0;
                    mc[i] = (mc[i] + 1) % m;
                end else begin
                    mw[i] = (mc[i] == 0) ? 1 : 0;
                    mc[i] = (mc[i] + m - 1) % m;
                end
            end else begin
                mw[i] = 0; mle[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("count", i, obs_count(i), mc[i]);
            chk("wrap", i, {31'd0, wrap_v[i]}, mw[i]);
            chk("load_err", i, {31'd0, lerr_v[i]}, mle[i]);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic u, input logic c,
                        input logic l, input logic [3:0] v);
        rst = r; en = e; up_dn = u; clear = c; load = l; load_val = v;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mw[i] = 0; mle[i] = 0;
        end
        // Reset wins over everything else.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        // Count up through the wrap.
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Load 2, count down through the wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        // Priority: clear beats load beats en.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
        // Out-of-range loads: single, then held for two cycles.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        // Reset at the would-be wrap edge, then hold.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        // Free-running up, exercising full-range and minimum moduli.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Randomised mix with direction changes every cycle.
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
